// File: rtl/ex_hilo_unit.sv
// Execute-stage HI/LO unit: iterative mult/multu/div/divu (33-cycle latency) plus mthi/mtlo.
// Optional macro HILO_FAST_MUL_EN makes mult/multu single-pass (IDLE -> FIX) with a combinational product.
module ex_hilo_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start_In,
  input  logic [1:0]  Op_In,
  input  logic [31:0] OperandA_In,
  input  logic [31:0] OperandB_In,
  input  logic        mthi_In,
  input  logic        mtlo_In,
  input  logic [31:0] WriteData_In,
  output logic        Busy_Out,
  output logic        Done_Out,
  output logic        DivByZero_Out,
  output logic [31:0] Hi_Out,
  output logic [31:0] Lo_Out
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d, dbz_q, dbz_d;

  logic        signed_in;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic        neg_prod, neg_rem;
  logic [63:0] prod_mag, prod_fix;
  logic [31:0] quo_fix, rem_fix, a_raw;

  assign signed_in = ~Op_In[0];
  assign a_mag = (signed_in && OperandA_In[31]) ? 32'd0 - OperandA_In : OperandA_In;
  assign b_mag = (signed_in && OperandB_In[31]) ? 32'd0 - OperandB_In : OperandB_In;

  // Multiply: multiplier sits in acc[31:0] and shifts out LSB-first as the product shifts in.
  assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? a_q : 32'd0)};

  // Divide: dividend shifts out of acc[31:0] MSB-first, quotient bits shift in behind it.
  assign div_shift = {rem_q, acc_q[31]};
  assign div_ge    = (div_shift >= {1'b0, b_q});

  assign neg_prod = ~op_q[0] & (sa_q ^ sb_q);
  assign neg_rem  = ~op_q[0] & sa_q;

`ifdef HILO_FAST_MUL_EN
  assign prod_mag = {32'd0, a_q} * {32'd0, b_q};
`else
  assign prod_mag = acc_q;
`endif

  assign prod_fix = neg_prod ? 64'd0 - prod_mag : prod_mag;
  assign quo_fix  = neg_prod ? 32'd0 - acc_q[31:0] : acc_q[31:0];
  assign rem_fix  = neg_rem ? 32'd0 - rem_q : rem_q;
  assign a_raw    = neg_rem ? 32'd0 - a_q : a_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_In) begin
          op_d    = Op_In;
          sa_d    = OperandA_In[31];
          sb_d    = OperandB_In[31];
          a_d     = a_mag;
          b_d     = b_mag;
          acc_d   = Op_In[1] ? {32'd0, a_mag} : {32'd0, b_mag};
          rem_d   = 32'd0;
          cnt_d   = 5'd31;
          state_d = CALC;
`ifdef HILO_FAST_MUL_EN
          if (!Op_In[1]) state_d = FIX;
`endif
        end else begin
          if (mthi_In) hi_d = WriteData_In;
          if (mtlo_In) lo_d = WriteData_In;
        end
      end
      CALC: begin
        if (op_q[1]) begin
          rem_d = div_ge ? div_shift[31:0] - b_q : div_shift[31:0];
          acc_d = {acc_q[63:32], acc_q[30:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        if (cnt_q == 5'd0) state_d = FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (op_q[1]) begin
          if (b_q == 32'd0) begin
            hi_d  = a_raw;
            lo_d  = 32'hFFFF_FFFF;
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      rem_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Busy_Out      = (state_q != IDLE);
  assign Done_Out      = done_q;
  assign DivByZero_Out = dbz_q;
  assign Hi_Out        = hi_q;
  assign Lo_Out        = lo_q;

endmodule
